// File: rtl/project_controller.sv
`default_nettype none
// ============================================================================
//  Module   : project_controller
//  Purpose  : Sequencer for a seed/count word generator: loads seed and count,
//             emits one handshaked result word per count, then pulses done.
//             Optional macro CTRL_STALL_CNT_EN adds the stall_cnt output.
//  Revision : 1.0  initial release
// ============================================================================
module project_controller #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             eq,
   input  logic [WIDTH-1:0] z,
   output logic             lda,
   output logic             ldb,
   output logic             decb,
   output logic             in_sel,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] word_cnt
`ifdef CTRL_STALL_CNT_EN
   ,
   output logic [WIDTH-1:0] stall_cnt
`endif
);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_LDA   = 3'd1;
   localparam logic [2:0] c_LDB   = 3'd2;
   localparam logic [2:0] c_CHECK = 3'd3;
   localparam logic [2:0] c_EMIT  = 3'd4;
   localparam logic [2:0] c_DONE  = 3'd5;

   logic [2:0]       r_state;
   logic [2:0]       w_state_next;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_word_cnt;
   logic             w_handshake;
   logic             w_run_start;

   assign w_run_start = (r_state == c_IDLE) && start;
   // rst masks the handshake so an aborted run never leaks a decrement
   assign w_handshake = (r_state == c_EMIT) && r_out_valid && out_ready && !rst;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_IDLE:  if (start) w_state_next = c_LDA;
         c_LDA:   w_state_next = c_LDB;
         c_LDB:   w_state_next = c_CHECK;
         c_CHECK: w_state_next = eq ? c_DONE : c_EMIT;
         c_EMIT:  if (w_handshake) w_state_next = c_CHECK;
         c_DONE:  w_state_next = c_IDLE;
         default: w_state_next = c_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= c_IDLE;
         r_out_data  <= {WIDTH{1'b0}};
         r_out_valid <= 1'b0;
         r_word_cnt  <= {WIDTH{1'b0}};
      end else begin
         r_state <= w_state_next;
         if (w_run_start) begin
            r_word_cnt <= {WIDTH{1'b0}};
         end
         if ((r_state == c_CHECK) && !eq) begin
            r_out_data  <= z;
            r_out_valid <= 1'b1;
         end
         if (w_handshake) begin
            r_out_valid <= 1'b0;
            r_word_cnt  <= r_word_cnt + WIDTH'(1);
         end
      end
   end

`ifdef CTRL_STALL_CNT_EN
   logic [WIDTH-1:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (rst || w_run_start) begin
         r_stall_cnt <= {WIDTH{1'b0}};
      end else if ((r_state == c_EMIT) && !out_ready && !(&r_stall_cnt)) begin
         r_stall_cnt <= r_stall_cnt + WIDTH'(1);
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

   assign lda       = (r_state == c_LDA);
   assign ldb       = (r_state == c_LDB);
   assign in_sel    = (r_state == c_LDB);
   assign decb      = w_handshake;
   assign busy      = (r_state != c_IDLE);
   assign done      = (r_state == c_DONE);
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign word_cnt  = r_word_cnt;

endmodule
`default_nettype wire

// File: doc/project_controller.md
PROJECT_CONTROLLER -- requirements
Module: project_controller

Interface
REQ-001 Parameter: WIDTH, 16, width of data_in, z, out_data, word_cnt.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 Port: start  input  1  request one generation run; honoured only in IDLE.
REQ-005 Port: eq  input  1  datapath counter-is-zero flag; combinational from the counter value.
REQ-006 Port: z  input  WIDTH  datapath result word.
REQ-007 Port: lda  output  1  load seed register from data bus.
REQ-008 Port: ldb  output  1  load iteration counter from data bus.
REQ-009 Port: decb  output  1  decrement iteration counter.
REQ-010 Port: in_sel  output  1  source select for data_in supplier: 0 = seed word, 1 = count word.
REQ-011 Port: out_data  output  WIDTH  registered result word.
REQ-012 Port: out_valid  output  1  out_data valid.
REQ-013 Port: out_ready  input  1  consumer accepts out_data.
REQ-014 Port: busy  output  1  high in every state except IDLE.
REQ-015 Port: done  output  1  one-cycle pulse at end of run.
REQ-016 Port: word_cnt  output  WIDTH  words accepted by the consumer in the current/last run.

Function
REQ-017 FSM states: IDLE, LDA, LDB, CHECK, EMIT, DONE; binary-encoded, one state register.
REQ-018 IDLE: lda/ldb/decb/out_valid = 0; start=1 -> LDA, word_cnt cleared to 0 on that edge.
REQ-019 LDA: lda=1, in_sel=0 for exactly one cycle; -> LDB unconditionally.
REQ-020 LDB: ldb=1, in_sel=1 for exactly one cycle; -> CHECK unconditionally.
REQ-021 CHECK: eq=1 -> DONE; eq=0 -> out_data<=z, out_valid<=1, -> EMIT.
REQ-022 EMIT: out_valid held high, out_data stable until handshake (out_valid & out_ready).
REQ-023 EMIT handshake cycle: decb=1 combinationally that cycle, word_cnt+1 (wraps modulo 2^WIDTH), out_valid<=0, -> CHECK.
REQ-024 EMIT with out_ready=0: no decb, no state change, indefinite stall.
REQ-025 DONE: done=1 for one cycle, -> IDLE; start in DONE ignored.
REQ-026 Count N loaded in LDB -> exactly N words emitted, N decb pulses; N=0 -> zero words, done 2 cycles after LDB.
REQ-027 lda, ldb, decb mutually exclusive every cycle; at most one high.
REQ-028 start while busy ignored, no effect on state or counters.
REQ-029 Latency start sampled -> first out_valid: 4 cycles (LDA, LDB, CHECK, EMIT asserted on 4th edge).
REQ-030 Minimum per-word period with out_ready tied high: 2 cycles (CHECK + EMIT).

Reset
REQ-031 rst=1 at a clock edge -> state IDLE; out_data=0, out_valid=0, word_cnt=0, done=0, busy=0, lda=ldb=decb=0, in_sel=0.
REQ-032 rst has priority over start, handshake and all transitions; reset mid-run aborts without done pulse or decb.

Configuration
REQ-033 Macro CTRL_STALL_CNT_EN defined: extra output stall_cnt (WIDTH) counts EMIT cycles with out_ready=0, cleared on rst and on IDLE->LDA, saturates at all-ones.
REQ-034 CTRL_STALL_CNT_EN undefined: stall_cnt port and logic absent; all other behaviour identical.

Verification
REQ-035 rst 2 cycles, start pulse, count=3, out_ready=1 -> lda, ldb one cycle each, 3 out_valid handshakes, 3 decb, done pulse, word_cnt=3.
REQ-036 count=0 -> no out_valid, no decb, done 2 cycles after ldb, word_cnt=0.
REQ-037 count=2, out_ready low 5 cycles in first EMIT -> out_data stable, no decb, stall_cnt=5 (macro on), then 2 words.
REQ-038 start pulsed during EMIT -> ignored; run completes with word_cnt=count.
REQ-039 rst asserted in EMIT of count=4 run -> next cycle IDLE, all outputs 0, no done pulse.
REQ-040 Every cycle of all runs -> lda+ldb+decb <= 1; busy=0 only in IDLE.
